// File: rtl/router_output_engine.sv
// rtl/router_output_engine.sv - per-destination round-robin packet router with byte serializer and drop path
// Each destination owns an IDLE->LOADED->SEND engine; illegal destinations are acknowledged and counted.
module router_output_engine #(
  parameter int NODES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NODES-1:0]          data_ready,
  input  logic [NODES-1:0][3:0][7:0] packet_in,
  output logic [NODES-1:0]          data_routed,
  input  logic [NODES-1:0]          free_outbound,
  output logic [NODES-1:0]          put_outbound,
  output logic [NODES-1:0][7:0]     payload_outbound,
  output logic [7:0]                drop_count
);

  localparam int PW = $clog2(NODES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    SEND   = 2'd2
  } state_t;

  state_t          state    [NODES];
  logic [PW-1:0]   rr_ptr   [NODES];
  logic [3:0][7:0] pkt      [NODES];
  logic [1:0]      byte_idx [NODES];

  logic [3:0]       dest [NODES];
  logic [NODES-1:0] legal;
  logic [NODES-1:0] eligible;

  // A source acknowledged this cycle still shows data_ready, so it must be masked.
  assign eligible = data_ready & ~data_routed;

  always_comb begin
    for (int s = 0; s < NODES; s++) begin
      dest[s]  = packet_in[s][3][3:0];
      legal[s] = ({1'b0, packet_in[s][3][3:0]} < 5'(NODES));
    end
  end

  logic [NODES-1:0] grant_valid;
  logic [PW-1:0]    grant_src [NODES];
  logic [NODES-1:0] ack_next;
  logic             drop_valid;
  logic [PW-1:0]    cand;

  always_comb begin
    ack_next   = '0;
    drop_valid = 1'b0;
    cand       = '0;
    for (int d = 0; d < NODES; d++) begin
      grant_valid[d] = 1'b0;
      grant_src[d]   = '0;
      cand           = rr_ptr[d];
      for (int k = 0; k < NODES; k++) begin
        cand = (cand == PW'(NODES - 1)) ? '0 : cand + 1'b1;
        if (state[d] == IDLE && !grant_valid[d] && eligible[cand] &&
            legal[cand] && dest[cand] == 4'(d)) begin
          grant_valid[d] = 1'b1;
          grant_src[d]   = cand;
        end
      end
      if (grant_valid[d]) ack_next[grant_src[d]] = 1'b1;
    end
    // Drop path serves only the lowest-numbered illegal source per edge.
    for (int s = 0; s < NODES; s++) begin
      if (!drop_valid && eligible[s] && !legal[s]) begin
        drop_valid  = 1'b1;
        ack_next[s] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_routed      <= '0;
      put_outbound     <= '0;
      payload_outbound <= '0;
      drop_count       <= '0;
      for (int d = 0; d < NODES; d++) begin
        state[d]    <= IDLE;
        rr_ptr[d]   <= PW'(NODES - 1);
        pkt[d]      <= '0;
        byte_idx[d] <= '0;
      end
    end else begin
      data_routed <= ack_next;
      if (drop_valid && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      for (int d = 0; d < NODES; d++) begin
        case (state[d])
          IDLE: begin
            if (grant_valid[d]) begin
              pkt[d]    <= packet_in[grant_src[d]];
              rr_ptr[d] <= grant_src[d];
              state[d]  <= LOADED;
            end
          end
          LOADED: begin
            if (free_outbound[d]) begin
              state[d]            <= SEND;
              byte_idx[d]         <= 2'd3;
              put_outbound[d]     <= 1'b1;
              payload_outbound[d] <= pkt[d][3];
            end
          end
          SEND: begin
            if (byte_idx[d] == 2'd0) begin
              state[d]            <= IDLE;
              put_outbound[d]     <= 1'b0;
              payload_outbound[d] <= 8'h00;
            end else begin
              byte_idx[d]         <= byte_idx[d] - 2'd1;
              payload_outbound[d] <= pkt[d][byte_idx[d] - 2'd1];
            end
          end
          default: begin
            state[d]            <= IDLE;
            put_outbound[d]     <= 1'b0;
            payload_outbound[d] <= 8'h00;
          end
        endcase
      end
    end
  end

endmodule
